// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle for the sequential binary-to-BCD converter.
// master drives start/bin; slave (the converter) returns busy/done/bcd/ovf.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter, one bit per clock.
// Optional macro BIN2BCD_SAT_EN: track overflow, raise ovf and saturate bcd to all 9s.
// Without it, ovf is tied low and bcd carries the result modulo 10^DIGITS.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic          clk,
  input logic          rst_n,
  bin2bcd_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]   r_scratch;
  logic [BW-1:0]   r_bcd;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_result;

`ifdef BIN2BCD_SAT_EN
  localparam logic [BW-1:0] NINES = {DIGITS{4'h9}};
  logic r_sticky;
  logic r_ovf;
`endif

  // Add-3 adjust of every scratch digit that is 5 or more, ahead of the shift.
  always_comb begin
    w_adj = r_scratch;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
    end
  end

`ifdef BIN2BCD_SAT_EN
  // Value published at DONE: saturated to all 9s when any bit left the top digit.
  always_comb begin
    w_result = r_sticky ? NINES : r_scratch;
  end
`else
  // Value published at DONE: raw scratch, i.e. bin modulo 10^DIGITS.
  always_comb begin
    w_result = r_scratch;
  end
`endif

  // Conversion FSM with registered busy/done/bcd/ovf.
  // busy is cleared only from IDLE so it stays high through the done strobe cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef BIN2BCD_SAT_EN
      r_sticky  <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_shift   <= bus.bin;
            r_scratch <= '0;
            r_cnt     <= CW'(WIDTH);
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
`ifdef BIN2BCD_SAT_EN
            r_sticky  <= 1'b0;
`endif
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_scratch <= {w_adj[BW-2:0], r_shift[WIDTH-1]};
          r_shift   <= r_shift << 1;
          r_cnt     <= r_cnt - CW'(1);
`ifdef BIN2BCD_SAT_EN
          r_sticky  <= r_sticky | w_adj[BW-1];
`endif
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_bcd   <= w_result;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
`ifdef BIN2BCD_SAT_EN
          r_ovf   <= r_sticky;
`endif
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;
`ifdef BIN2BCD_SAT_EN
  assign bus.ovf  = r_ovf;
`else
  assign bus.ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq (8-bit default instance and a
// 10-bit/3-digit instance). Expected results come from a decimal model.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) a_if ();
  bin2bcd_seq_if #(.WIDTH(10), .DIGITS(3)) b_if ();

  bin2bcd_seq #(.WIDTH(8),  .DIGITS(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  typedef struct packed {
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input int unsigned v);
    exp_t e;
    int unsigned r;
    e = '0;
    r = v;
`ifdef BIN2BCD_SAT_EN
    if (v >= 1000) begin
      e.ovf = 1'b1;
      e.bcd = 12'h999;
      return e;
    end
`endif
    for (int i = 0; i < 3; i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return e;
  endfunction

  // Called at a negedge: start is seen by the next posedge, then dropped; bin scrambled.
  task automatic drive_start(input bit sel, input int unsigned val);
    if (sel) begin b_if.start = 1'b1; b_if.bin = 10'(val); end
    else     begin a_if.start = 1'b1; a_if.bin = 8'(val);  end
    sb.push_back(model(val));
    @(negedge clk);
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    a_if.bin   = 8'($urandom);
    b_if.bin   = 10'($urandom);
  endtask

  task automatic wait_done(input bit sel, output int n);
    n = 0;
    while ((sel ? b_if.done : a_if.done) !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({a_if.busy, a_if.done, a_if.ovf} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags_a got %b want 000", {a_if.busy, a_if.done, a_if.ovf});
    end
    n_vec++;
    if (a_if.bcd !== 12'h000) begin
      n_err++; $display("FAIL reset_bcd_a got %h want 000", a_if.bcd);
    end
    n_vec++;
    if ({b_if.busy, b_if.done, b_if.ovf, b_if.bcd} !== 15'h0) begin
      n_err++; $display("FAIL reset_b got %h want 0", {b_if.busy, b_if.done, b_if.ovf, b_if.bcd});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int n, nb;
    exp_t e;
    drive_start(0, 0);
    nb = 0; n = 0;
    while (a_if.done !== 1'b1 && n < 60) begin
      if (a_if.busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n != 9) begin n_err++; $display("FAIL zero_latency got %0d want 9", n); end
    e = sb.pop_front();
    n_vec++;
    if ({a_if.bcd, a_if.ovf} !== {e.bcd, e.ovf}) begin
      n_err++; $display("FAIL zero_result got %h/%b want %h/%b", a_if.bcd, a_if.ovf, e.bcd, e.ovf);
    end
    while (a_if.busy === 1'b1 && n < 60) begin
      nb++;
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (nb != 10) begin n_err++; $display("FAIL zero_busy_cycles got %0d want 10", nb); end
  endtask

  task automatic test_back_to_back();
    int n, t1, t2;
    exp_t e;
    @(negedge clk);
    drive_start(0, 255);
    wait_done(0, n);
    t1 = cyc;
    e = sb.pop_front();
    n_vec++;
    if (n != 9 || a_if.bcd !== e.bcd || a_if.bcd !== 12'h255) begin
      n_err++; $display("FAIL b2b_first lat %0d bcd %h want lat 9 bcd %h", n, a_if.bcd, e.bcd);
    end
    n = 0;
    while (a_if.busy === 1'b1 && n < 20) begin @(negedge clk); n++; end
    drive_start(0, 99);
    n_vec++;
    if (a_if.busy !== 1'b1 || a_if.bcd !== 12'h255) begin
      n_err++; $display("FAIL b2b_hold busy %b bcd %h want 1 255", a_if.busy, a_if.bcd);
    end
    wait_done(0, n);
    t2 = cyc;
    e = sb.pop_front();
    n_vec++;
    if (a_if.bcd !== e.bcd || a_if.ovf !== e.ovf) begin
      n_err++; $display("FAIL b2b_second got %h/%b want %h/%b", a_if.bcd, a_if.ovf, e.bcd, e.ovf);
    end
    n_vec++;
    if (t2 - t1 != 11) begin n_err++; $display("FAIL b2b_gap got %0d want 11", t2 - t1); end
  endtask

  task automatic test_hold_start();
    int nd, j1, j2;
    exp_t e;
    @(negedge clk);
    sb.push_back(model(123));
    sb.push_back(model(123));
    nd = 0; j1 = 0; j2 = 0;
    for (int j = 0; j < 34; j++) begin
      if (a_if.done === 1'b1) begin
        nd++;
        if (nd == 1) j1 = j; else j2 = j;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_vec++;
          if (a_if.bcd !== e.bcd || a_if.bcd !== 12'h123) begin
            n_err++; $display("FAIL hold_result got %h want %h", a_if.bcd, e.bcd);
          end
        end
      end
      a_if.start = (j < 20);
      a_if.bin   = 8'd123;
      @(negedge clk);
    end
    n_vec++;
    if (nd != 2 || j2 - j1 != 10) begin
      n_err++; $display("FAIL hold_count dones %0d gap %0d want 2 10", nd, j2 - j1);
    end
    sb.delete();
  endtask

  task automatic test_busy_pulses();
    int nd;
    exp_t e;
    @(negedge clk);
    drive_start(0, 123);
    nd = 0;
    for (int j = 0; j < 25; j++) begin
      if (a_if.done === 1'b1) begin
        nd++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_vec++;
          if (a_if.bcd !== e.bcd) begin
            n_err++; $display("FAIL pulse_result got %h want %h", a_if.bcd, e.bcd);
          end
        end
      end
      a_if.start = (j == 2 || j == 8);
      a_if.bin   = 8'($urandom);
      @(negedge clk);
    end
    n_vec++;
    if (nd != 1) begin n_err++; $display("FAIL pulse_dones got %0d want 1", nd); end
    sb.delete();
  endtask

  task automatic test_abort();
    int nd, n;
    exp_t e;
    @(negedge clk);
    drive_start(0, 200);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a_if.busy, a_if.done, a_if.ovf, a_if.bcd} !== 15'h0) begin
      n_err++; $display("FAIL abort_outputs got %h want 0", {a_if.busy, a_if.done, a_if.ovf, a_if.bcd});
    end
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (a_if.done === 1'b1) nd++;
    end
    n_vec++;
    if (nd != 0) begin n_err++; $display("FAIL abort_no_done got %0d want 0", nd); end
    drive_start(0, 7);
    wait_done(0, n);
    e = sb.pop_front();
    n_vec++;
    if (n != 9 || a_if.bcd !== e.bcd || a_if.bcd !== 12'h007) begin
      n_err++; $display("FAIL abort_restart lat %0d bcd %h want 9 %h", n, a_if.bcd, e.bcd);
    end
  endtask

  task automatic test_wide();
    int n;
    exp_t e;
    @(negedge clk);
    drive_start(1, 1023);
    wait_done(1, n);
    e = sb.pop_front();
    n_vec++;
    if (n != 11) begin n_err++; $display("FAIL wide_latency got %0d want 11", n); end
    n_vec++;
    if (b_if.bcd !== e.bcd || b_if.ovf !== e.ovf) begin
      n_err++; $display("FAIL wide_1023 got %h/%b want %h/%b", b_if.bcd, b_if.ovf, e.bcd, e.ovf);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (b_if.bcd !== e.bcd || b_if.ovf !== e.ovf) begin
      n_err++; $display("FAIL wide_hold got %h/%b want %h/%b", b_if.bcd, b_if.ovf, e.bcd, e.ovf);
    end
    drive_start(1, 999);
    wait_done(1, n);
    e = sb.pop_front();
    n_vec++;
    if (b_if.bcd !== e.bcd || b_if.ovf !== e.ovf || e.bcd !== 12'h999) begin
      n_err++; $display("FAIL wide_999 got %h/%b want %h/%b", b_if.bcd, b_if.ovf, e.bcd, e.ovf);
    end
  endtask

  task automatic test_sweep();
    int n;
    exp_t e;
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      drive_start(0, v);
      wait_done(0, n);
      e = sb.pop_front();
      n_vec++;
      if (n >= 60 || a_if.bcd !== e.bcd) begin
        n_err++; $display("FAIL sweep_bcd v=%0d got %h want %h lat %0d", v, a_if.bcd, e.bcd, n);
      end
      n_vec++;
      if (a_if.ovf !== 1'b0) begin
        n_err++; $display("FAIL sweep_ovf v=%0d got %b want 0", v, a_if.ovf);
      end
    end
  endtask

  initial begin
    a_if.start = 1'b0; a_if.bin = '0;
    b_if.start = 1'b0; b_if.bin = '0;
    test_reset();
    test_zero();
    test_back_to_back();
    test_hold_start();
    test_busy_pulses();
    test_abort();
    test_wide();
    test_sweep();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end
endmodule
